// File: rtl/uart_rx_deserializer_pkg.sv
// uart_pkg: shared state type and line-level constants for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_e;

  localparam int   UART_DATA_BITS   = 8;
  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// uart_rx_deserializer_if: byte-stream side of the UART receiver.
// master = receiver (produces bytes and status), slave = byte consumer.
interface uart_rx_deserializer_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] data;
  logic                      valid;
  logic                      ready;
  logic                      frame_err;
  logic                      overrun;
  logic                      busy;

  modport master (
    output data, valid, frame_err, overrun, busy,
    input  ready
  );

  modport slave (
    input  data, valid, frame_err, overrun, busy,
    output ready
  );

endinterface

// File: rtl/uart_rx_deserializer_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous serial line.
// Flops reset to the idle level so a reset never looks like a start bit.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic real_clk,
  input  logic real_rst,
  input  logic rx_in,
  output logic rx_out
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // shift the raw line into the two-stage chain
  always_comb begin
    sync_d = {sync_q[0], rx_in};
  end

  // synchronizer flops
  always_ff @(posedge real_clk or posedge real_rst) begin
    if (real_rst) sync_q <= {2{UART_IDLE_LEVEL}};
    else          sync_q <= sync_d;
  end

  assign rx_out = sync_q[1];

endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: UART receiver for start(0), D7..D0 MSB first, stop(1).
// Delivers bytes on a valid/ready port, pulses frame_err on a bad stop bit and
// holds a sticky overrun flag when a byte arrives while the last is unread.
// Build option UART_RX_SYNC_EN: rx goes through a 2-flop synchronizer first
// (all latencies +2 cycles); without it rx must be synchronous to real_clk.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8
) (
  input  logic                   real_clk,
  input  logic                   real_rst,
  input  logic                   rx,
  uart_rx_deserializer_if.master rx_if
);

  localparam int                 HALF       = (CLKS_PER_BIT - 1) / 2;
  localparam int                 CNT_W      = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0]   CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   CNT_HALF   = CNT_W'((HALF == 0) ? 0 : HALF - 1);
  localparam logic [2:0]         IDX_MSB    = 3'(UART_DATA_BITS - 1);

  if (DATA_BITS != UART_DATA_BITS) begin : g_check_data_bits
    $error("uart_rx_deserializer: DATA_BITS must be %0d", UART_DATA_BITS);
  end
  if (CLKS_PER_BIT < 1) begin : g_check_clks_per_bit
    $error("uart_rx_deserializer: CLKS_PER_BIT must be >= 1");
  end

  logic rx_s;
`ifdef UART_RX_SYNC_EN
  uart_rx_sync u_rx_sync (
    .real_clk (real_clk),
    .real_rst (real_rst),
    .rx_in    (rx),
    .rx_out   (rx_s)
  );
`else
  assign rx_s = rx;
`endif

  uart_rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overrun_q, overrun_d;
  logic                      frame_good;
  logic                      handshake;

  assign handshake = valid_q & rx_if.ready;

  // frame FSM plus counters, then the output/handshake register update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    frame_good  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_s == UART_START_LEVEL) begin
          if (HALF == 0) begin
            state_d = DATA;
            cnt_d   = CNT_RELOAD;
            idx_d   = IDX_MSB;
          end else begin
            state_d = START;
            cnt_d   = CNT_HALF;
          end
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (rx_s == UART_START_LEVEL) begin
            state_d = DATA;
            cnt_d   = CNT_RELOAD;
            idx_d   = IDX_MSB;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d[idx_q] = rx_s;
          cnt_d          = CNT_RELOAD;
          if (idx_q == 3'd0) state_d = STOP;
          else               idx_d   = idx_q - 3'd1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (rx_s == UART_IDLE_LEVEL) frame_good  = 1'b1;
          else                         frame_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (frame_good) begin
      if (!valid_q || handshake) begin
        data_d    = shift_q;
        valid_d   = 1'b1;
        overrun_d = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (handshake) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // state and datapath registers
  always_ff @(posedge real_clk or posedge real_rst) begin
    if (real_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= IDX_MSB;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_if.data      = data_q;
  assign rx_if.valid     = valid_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.overrun   = overrun_q;
  assign rx_if.busy      = (state_q != IDLE);

endmodule
